// File: rtl/ifmaps_pkg.sv
// Shared definitions for the ifmap stream unpacker and the preload stage.
//   ACT_W          : bits per activation
//   LANES_PER_BEAT : activations packed into one stream beat
//   state_t        : unpacker FSM states
//   ch_eff_clamp   : maps a raw input_channel value onto 1..mac_num
package ifmaps_pkg;
  localparam int ACT_W          = 5;
  localparam int LANES_PER_BEAT = 6;
  localparam int BEAT_BITS      = ACT_W * LANES_PER_BEAT;

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  // 0 and anything above the lane count both mean "use every lane".
  function automatic logic [8:0] ch_eff_clamp(input logic [8:0] ch, input int mac_num);
    if (ch == 9'd0 || int'(ch) > mac_num) return 9'(mac_num);
    return ch;
  endfunction
endpackage

// File: rtl/ifmaps_lane_writer.sv
// Per-lane write decode for the vector register.
//   i_en       : a beat is being accepted this cycle
//   i_lane_idx : first lane written by this beat
//   i_ch_eff   : active lane count; lanes at or above it are never written
//   i_acts     : six packed activations of the beat
//   o_we       : per-lane write enable
//   o_data     : per-lane write data, lane i at [5i+4:5i]
module ifmaps_lane_writer
  import ifmaps_pkg::*;
#(
  parameter int MAC_NUM = 256
) (
  input  logic                     i_en,
  input  logic [8:0]               i_lane_idx,
  input  logic [8:0]               i_ch_eff,
  input  logic [BEAT_BITS-1:0]     i_acts,
  output logic [MAC_NUM-1:0]       o_we,
  output logic [ACT_W*MAC_NUM-1:0] o_data
);
  for (genvar i = 0; i < MAC_NUM; i++) begin : g_lane
    logic [9:0]       w_off;
    logic [ACT_W-1:0] w_act;

    // Lanes below the pointer wrap to a large offset and fall out of range.
    assign w_off   = 10'(i) - {1'b0, i_lane_idx};
    assign o_we[i] = i_en && (w_off < 10'(LANES_PER_BEAT)) && (10'(i) < {1'b0, i_ch_eff});

    always_comb begin
      w_act = '0;
      for (int k = 0; k < LANES_PER_BEAT; k++)
        if (w_off[2:0] == 3'(k)) w_act = i_acts[ACT_W*k +: ACT_W];
    end

    assign o_data[ACT_W*i +: ACT_W] = w_act;
  end
endmodule

// File: rtl/axis_ifmaps_unpack.sv
// AXI-Stream slave that packs 6 activations per beat into a full MAC vector.
//   clk, rst          : clock, synchronous active-high reset
//   s_axis_*          : ifmap word stream (tdata[29:0] = 6 x 5-bit activations)
//   input_channel     : active lanes per vector (0 or >MAC_NUM => MAC_NUM)
//   m_vec_data/valid  : assembled vector, held stable until m_vec_ready
//   m_vec_ready       : consumer (preload FIFO not-full)
//   tlast_err         : one-cycle pulse after a tlast that cut a vector short
module axis_ifmaps_unpack
  import ifmaps_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int MAC_NUM              = 256
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  input  logic [8:0]                      input_channel,
  output logic [ACT_W*MAC_NUM-1:0]        m_vec_data,
  output logic                            m_vec_valid,
  input  logic                            m_vec_ready,
  output logic                            tlast_err
);
  state_t                   r_state;
  logic [8:0]               r_lane_idx;
  logic [8:0]               r_ch_eff;
  logic [8:0]               w_ch_cur;
  logic                     w_accept;
  logic                     w_done;
  logic [MAC_NUM-1:0]       w_we;
  logic [ACT_W*MAC_NUM-1:0] w_wdata;

  if (C_S_AXIS_TDATA_WIDTH > BEAT_BITS) begin : g_spare
    logic w_unused_tdata;
    assign w_unused_tdata = ^s_axis_tdata[C_S_AXIS_TDATA_WIDTH-1:BEAT_BITS];
  end

  // Channel count is taken live on the first beat, then frozen for the vector.
  assign w_ch_cur      = (r_lane_idx == 9'd0) ? ch_eff_clamp(input_channel, MAC_NUM) : r_ch_eff;
  assign s_axis_tready = (r_state == FILL) & ~rst;
  assign w_accept      = s_axis_tvalid & s_axis_tready;
  assign w_done        = ({1'b0, r_lane_idx} + 10'(LANES_PER_BEAT)) >= {1'b0, w_ch_cur};

  ifmaps_lane_writer #(.MAC_NUM(MAC_NUM)) u_writer (
    .i_en       (w_accept),
    .i_lane_idx (r_lane_idx),
    .i_ch_eff   (w_ch_cur),
    .i_acts     (s_axis_tdata[BEAT_BITS-1:0]),
    .o_we       (w_we),
    .o_data     (w_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= FILL;
      r_lane_idx  <= '0;
      r_ch_eff    <= '0;
      m_vec_data  <= '0;
      m_vec_valid <= 1'b0;
      tlast_err   <= 1'b0;
    end else begin
      tlast_err <= 1'b0;
      case (r_state)
        FILL: if (w_accept) begin
          if (r_lane_idx == 9'd0) r_ch_eff <= w_ch_cur;
          for (int i = 0; i < MAC_NUM; i++)
            if (w_we[i]) m_vec_data[ACT_W*i +: ACT_W] <= w_wdata[ACT_W*i +: ACT_W];
          // An early tlast closes the vector with whatever lanes were written.
          if (w_done || s_axis_tlast) begin
            r_state     <= HOLD;
            m_vec_valid <= 1'b1;
            r_lane_idx  <= '0;
            tlast_err   <= s_axis_tlast & ~w_done;
          end else begin
            r_lane_idx <= r_lane_idx + 9'(LANES_PER_BEAT);
          end
        end
        HOLD: if (m_vec_ready) begin
          // Clearing here keeps unwritten lanes of the next vector at zero.
          r_state     <= FILL;
          m_vec_valid <= 1'b0;
          m_vec_data  <= '0;
        end
        default: r_state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_axis_ifmaps_unpack.sv
module tb_axis_ifmaps_unpack;
  localparam int MAC = 256;
  localparam int VW  = 5 * MAC;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   tdata = '0;
  logic          tvalid = 1'b0;
  logic          tlast = 1'b0;
  logic [8:0]    ich = 9'd256;
  logic          m_ready = 1'b1;
  logic          tready, mvalid, terr;
  logic [VW-1:0] mdata;

  int            n_pass = 0;
  int            n_total = 0;
  int            err_cnt = 0;
  logic [VW-1:0] exp_q[$];

  always #5 clk = ~clk;

  axis_ifmaps_unpack #(.C_S_AXIS_TDATA_WIDTH(32), .MAC_NUM(MAC)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .s_axis_tlast  (tlast),
    .input_channel (ich),
    .m_vec_data    (mdata),
    .m_vec_valid   (mvalid),
    .m_vec_ready   (m_ready),
    .tlast_err     (terr)
  );

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic chk_vec(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    logic [VW-1:0] g, e;
    int lane;
    g = got; e = exp;
    n_total++;
    if (g === e) n_pass++;
    else begin
      lane = 0;
      for (int i = MAC - 1; i >= 0; i--) if (g[5*i +: 5] !== e[5*i +: 5]) lane = i;
      $display("FAIL %s: lane %0d got %h expected %h", nm, lane, g[5*lane +: 5], e[5*lane +: 5]);
    end
  endtask

  // Activation k of beat b = (6b+k) mod 32; bits 31:30 set to exercise the ignored field.
  function automatic logic [31:0] pat(input int b);
    logic [31:0] w;
    w = 32'hC000_0000;
    for (int k = 0; k < 6; k++) w[5*k +: 5] = 5'((6*b + k) % 32);
    return w;
  endfunction

  function automatic logic [VW-1:0] exp_mod(input int n);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[5*i +: 5] = 5'(i % 32);
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_ones(input int n);
    logic [VW-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[5*i +: 5] = 5'h1F;
    return v;
  endfunction

  // Scoreboard monitor: one pop per output handshake.
  always @(negedge clk) begin
    if (terr) err_cnt++;
    if (mvalid && m_ready) begin
      if (exp_q.size() == 0) chk("unexpected_vec", 1, 0);
      else chk_vec("vec_data", mdata, exp_q.pop_front());
    end
  end

  // Called and returns at posedge+1; holds the beat until it is accepted.
  task automatic beat(input logic [31:0] d, input logic l);
    logic acc;
    int   g;
    g = 0; tdata = d; tlast = l; tvalid = 1'b1;
    forever begin
      @(negedge clk); acc = tready;
      @(posedge clk); #1;
      if (acc) break;
      g++;
      if (g > 200) begin chk("beat_timeout", 0, 1); break; end
    end
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_pat(input int nb, input int chg_at, input int new_ch, input string nm);
    for (int b = 0; b < nb; b++) begin
      if (b == chg_at) ich = 9'(new_ch);
      beat(pat(b), 1'b0);
      if (b == nb - 2) chk({nm, "_valid_early"}, int'(mvalid), 0);
    end
    chk({nm, "_valid"}, int'(mvalid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tready", int'(tready), 0);
    chk("rst_valid", int'(mvalid), 0);
    chk_vec("rst_data", mdata, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tready", int'(tready), 1);
    chk("post_rst_err", int'(terr), 0);
    cyc(1);

    // 256 channels, back-to-back beats, one-cycle bubble
    ich = 9'd256;
    exp_q.push_back(exp_mod(256));
    run_pat(43, -1, 0, "t1");
    chk("t1_tready_hold", int'(tready), 0);
    cyc(1);
    chk("t1_tready_back", int'(tready), 1);

    // 10 channels of 1F, spare activations dropped, then backpressure
    ich = 9'd10;
    m_ready = 1'b0;
    exp_q.push_back(exp_ones(10));
    beat(32'hFFFF_FFFF, 1'b0);
    chk("t2_valid_early", int'(mvalid), 0);
    beat(32'hFFFF_FFFF, 1'b0);
    chk("t2_valid", int'(mvalid), 1);
    tvalid = 1'b1; tdata = pat(0);
    repeat (5) begin
      @(negedge clk);
      chk("t3_tready_hold", int'(tready), 0);
      chk("t3_valid_hold", int'(mvalid), 1);
      chk_vec("t3_hold_data", mdata, exp_ones(10));
    end
    @(posedge clk); #1;
    tvalid = 1'b0;
    m_ready = 1'b1;
    cyc(1);
    chk("t3_tready_after", int'(tready), 1);
    chk("t3_valid_after", int'(mvalid), 0);
    chk_vec("t3_cleared", mdata, '0);

    // 32 channels, tlast on the third beat
    ich = 9'd32;
    exp_q.push_back(exp_mod(18));
    beat(pat(0), 1'b0);
    beat(pat(1), 1'b0);
    beat(pat(2), 1'b1);
    chk("t4_valid", int'(mvalid), 1);
    chk("t4_err", int'(terr), 1);
    cyc(1);
    chk("t4_err_clear", int'(terr), 0);
    chk("t4_err_cycles", err_cnt, 1);

    // Reset mid-fill, then a clean vector
    ich = 9'd256;
    for (int b = 0; b < 20; b++) beat(32'hFFFF_FFFF, 1'b0);
    rst = 1'b1;
    cyc(1);
    chk("t5_rst_valid", int'(mvalid), 0);
    chk("t5_rst_tready", int'(tready), 0);
    chk_vec("t5_rst_data", mdata, '0);
    rst = 1'b0;
    exp_q.push_back(exp_mod(256));
    run_pat(43, -1, 0, "t5");

    // input_channel=0 means full width; mid-vector change ignored until next vector
    ich = 9'd0;
    exp_q.push_back(exp_mod(256));
    run_pat(43, -1, 0, "t6a");
    ich = 9'd256;
    exp_q.push_back(exp_mod(256));
    run_pat(43, 5, 12, "t6b");
    exp_q.push_back(exp_mod(12));
    run_pat(2, -1, 0, "t6c");

    cyc(3);
    chk("sb_empty", exp_q.size(), 0);
    chk("err_total", err_cnt, 1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
